// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of the single-port instruction RAM between fetch and debug
module imem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   logic               w_gnt_f, w_gnt_d, w_rd;
   logic               r_last;
   logic [RAM_LAT-1:0] r_vld, r_own;
   // grant the sole requester, or on contention the one not served last (r_last=1 means debug)
   always_comb begin
      w_gnt_f = ~reset & f_req & (~d_req | r_last);
      w_gnt_d = ~reset & d_req & (~f_req | ~r_last);
      w_rd    = w_gnt_f | (w_gnt_d & ~d_we);
   end
   assign f_gnt     = w_gnt_f;
   assign d_gnt     = w_gnt_d;
   assign ram_en    = w_gnt_f | w_gnt_d;
   assign ram_we    = w_gnt_d & d_we;
   assign ram_addr  = w_gnt_d ? d_addr : f_addr;
   assign ram_wdata = d_wdata;
   assign f_rdata   = ram_rdata;
   assign d_rdata   = ram_rdata;
   assign f_rvalid  = r_vld[RAM_LAT-1] & ~r_own[RAM_LAT-1];
   assign d_rvalid  = r_vld[RAM_LAT-1] & r_own[RAM_LAT-1];
   // round-robin pointer remembers who received the most recent grant
   always_ff @(posedge clk or posedge reset)
      if (reset) r_last <= 1'b1;
      else if (w_gnt_f | w_gnt_d) r_last <= w_gnt_d;
   // owner pipeline aligned with RAM latency; writes enter as invalid slots
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_vld <= '0;
         r_own <= '0;
      end else begin
         r_vld[0] <= w_rd;
         r_own[0] <= w_gnt_d;
         for (int i = 1; i < RAM_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_own[i] <= r_own[i-1];
         end
      end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of imem_arbiter at RAM latency 1 and 3
module tb_imem_arbiter;
   logic        clk = 1'b0;
   logic        reset, rst3;
   logic        f_req, d_req, d_we;
   logic [15:0] f_addr, d_addr;
   logic [31:0] d_wdata;
   logic        f_gnt1, f_rvalid1, d_gnt1, d_rvalid1, ram_en1, ram_we1;
   logic [31:0] f_rdata1, d_rdata1, ram_wdata1, ram_rdata1;
   logic [15:0] ram_addr1;
   logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3, ram_en3, ram_we3;
   logic [31:0] f_rdata3, d_rdata3, ram_wdata3, ram_rdata3;
   logic [15:0] ram_addr3;
   logic        ov_v = 1'b0;
   logic [15:0] ov_a = 16'h0;
   logic [31:0] ov_d = 32'h0;
   logic [31:0] p0 = 32'h0, p1 = 32'h0, p2 = 32'h0;
   int          n = 0, errs = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt1),
      .f_rvalid(f_rvalid1), .f_rdata(f_rdata1), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1),
      .d_rdata(d_rdata1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
      .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1));

   imem_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(3)) dut3 (
      .clk(clk), .reset(rst3), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt3),
      .f_rvalid(f_rvalid3), .f_rdata(f_rdata3), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
      .d_rdata(d_rdata3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
      .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3));

   // write-first latency-1 RAM: word = A000_<addr> unless overwritten (one-entry overlay)
   always @(posedge clk) begin
      if (ram_en1 && ram_we1) begin
         ov_v <= 1'b1;
         ov_a <= ram_addr1;
         ov_d <= ram_wdata1;
      end
      if (ram_en1)
         ram_rdata1 <= ram_we1 ? ram_wdata1 :
                       ((ov_v && ov_a == ram_addr1) ? ov_d : {16'hA000, ram_addr1});
   end

   // read-only latency-3 RAM
   always @(posedge clk) begin
      p0 <= ram_en3 ? {16'hA000, ram_addr3} : 32'h0;
      p1 <= p0;
      p2 <= p1;
   end
   assign ram_rdata3 = p2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        t, pv, po;
      logic [15:0] fa, da, pa;
      int          fcnt, dcnt;
      reset = 1'b1; rst3 = 1'b1;
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      f_addr = 16'h0; d_addr = 16'h5; d_wdata = 32'h0;
      #2;
      chk("rst_f_gnt", f_gnt1, 0);
      chk("rst_d_gnt", d_gnt1, 0);
      chk("rst_ram_en", ram_en1, 0);
      chk("rst_f_rvalid", f_rvalid1, 0);
      chk("rst_d_rvalid", d_rvalid1, 0);
      // release: both requesting, fetch wins first contention
      cyc(); reset = 1'b0; rst3 = 1'b0; #1;
      chk("c0_f_gnt", f_gnt1, 1);
      chk("c0_d_gnt", d_gnt1, 0);
      chk("c0_ram_addr", ram_addr1, 16'h0000);
      cyc(); f_addr = 16'h1; #1;
      chk("c1_d_gnt", d_gnt1, 1);
      chk("c1_f_gnt", f_gnt1, 0);
      chk("c1_ram_addr", ram_addr1, 16'h0005);
      chk("c1_f_rvalid", f_rvalid1, 1);
      chk("c1_f_rdata", f_rdata1, 32'hA0000000);
      chk("c1_d_rvalid", d_rvalid1, 0);
      // fetch only
      cyc(); d_req = 1'b0; #1;
      chk("c2_f_gnt", f_gnt1, 1);
      chk("c2_ram_addr", ram_addr1, 16'h0001);
      chk("c2_d_rvalid", d_rvalid1, 1);
      chk("c2_d_rdata", d_rdata1, 32'hA0000005);
      chk("c2_f_rvalid", f_rvalid1, 0);
      cyc(); f_addr = 16'h2; #1;
      chk("c3_f_gnt", f_gnt1, 1);
      chk("c3_f_rvalid", f_rvalid1, 1);
      chk("c3_f_rdata", f_rdata1, 32'hA0000001);
      chk("c3_d_rvalid", d_rvalid1, 0);
      cyc(); f_req = 1'b0; #1;
      chk("c4_f_gnt", f_gnt1, 0);
      chk("c4_ram_en", ram_en1, 0);
      chk("c4_f_rvalid", f_rvalid1, 1);
      chk("c4_f_rdata", f_rdata1, 32'hA0000002);
      cyc(); #1;
      chk("c5_f_rvalid", f_rvalid1, 0);
      chk("c5_d_rvalid", d_rvalid1, 0);
      // contention for 100 cycles: fetch was last, so debug goes first
      t = 1'b1; pv = 1'b0; po = 1'b0; pa = 16'h0;
      fa = 16'h100; da = 16'h200; fcnt = 0; dcnt = 0;
      for (int k = 0; k < 100; k++) begin
         cyc(); f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = fa; d_addr = da; #1;
         chk("ct_f_gnt", f_gnt1, !t);
         chk("ct_d_gnt", d_gnt1, t);
         chk("ct_ram_addr", ram_addr1, t ? da : fa);
         chk("ct_f_rvalid", f_rvalid1, pv && !po);
         chk("ct_d_rvalid", d_rvalid1, pv && po);
         if (pv) chk("ct_rdata", po ? d_rdata1 : f_rdata1, {16'hA000, pa});
         fcnt += int'(f_rvalid1);
         dcnt += int'(d_rvalid1);
         pv = 1'b1; po = t; pa = t ? da : fa;
         if (t) da++; else fa++;
         t = !t;
      end
      cyc(); f_req = 1'b0; d_req = 1'b0; #1;
      chk("dr_ram_en", ram_en1, 0);
      chk("dr_f_rvalid", f_rvalid1, 1);
      chk("dr_f_rdata", f_rdata1, {16'hA000, pa});
      fcnt += int'(f_rvalid1);
      dcnt += int'(d_rvalid1);
      chk("ct_f_count", fcnt, 50);
      chk("ct_d_count", dcnt, 50);
      // debug write then read of the same word
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEADBEEF; #1;
      chk("w_d_gnt", d_gnt1, 1);
      chk("w_ram_we", ram_we1, 1);
      chk("w_ram_wdata", ram_wdata1, 32'hDEADBEEF);
      chk("w_f_rvalid", f_rvalid1, 0);
      cyc(); d_we = 1'b0; #1;
      chk("r_d_gnt", d_gnt1, 1);
      chk("r_ram_we", ram_we1, 0);
      chk("r_d_rvalid", d_rvalid1, 0);
      cyc(); d_req = 1'b0; #1;
      chk("r_d_rvalid2", d_rvalid1, 1);
      chk("r_d_rdata", d_rdata1, 32'hDEADBEEF);
      // withdrawn debug write while fetch wins
      cyc(); f_req = 1'b1; f_addr = 16'h0003; d_req = 1'b1; d_we = 1'b1;
      d_addr = 16'h0020; d_wdata = 32'h12345678; #1;
      chk("wd_f_gnt", f_gnt1, 1);
      chk("wd_d_gnt", d_gnt1, 0);
      chk("wd_ram_we", ram_we1, 0);
      cyc(); f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
      chk("wd_f_rvalid", f_rvalid1, 1);
      chk("wd_f_rdata", f_rdata1, 32'hA0000003);
      chk("wd_d_rvalid", d_rvalid1, 0);
      cyc(); d_req = 1'b1; #1;
      chk("wd_rd_gnt", d_gnt1, 1);
      cyc(); d_req = 1'b0; #1;
      chk("wd_rd_rvalid", d_rvalid1, 1);
      chk("wd_rd_data", d_rdata1, 32'hA0000020);
      // latency 3: clean reset of the second instance
      cyc(); rst3 = 1'b1; #1;
      chk("l3_rst_gnt", f_gnt3, 0);
      cyc(); rst3 = 1'b0; f_req = 1'b1; f_addr = 16'h0007; #1;
      chk("l3_n_gnt", f_gnt3, 1);
      cyc(); f_req = 1'b0; #1;
      chk("l3_n1_rvalid", f_rvalid3, 0);
      cyc(); #1;
      chk("l3_n2_rvalid", f_rvalid3, 0);
      cyc(); #1;
      chk("l3_n3_rvalid", f_rvalid3, 1);
      chk("l3_n3_rdata", f_rdata3, 32'hA0000007);
      chk("l3_n3_d_rvalid", d_rvalid3, 0);
      cyc(); #1;
      chk("l3_n4_rvalid", f_rvalid3, 0);
      // latency 3: reset one cycle after grant discards the read
      cyc(); f_req = 1'b1; f_addr = 16'h0009; #1;
      chk("l3_m_gnt", f_gnt3, 1);
      cyc(); f_req = 1'b0; rst3 = 1'b1; #1;
      chk("l3_m1_rvalid", f_rvalid3, 0);
      cyc(); rst3 = 1'b0; #1;
      chk("l3_m2_rvalid", f_rvalid3, 0);
      cyc(); #1;
      chk("l3_m3_rvalid", f_rvalid3, 0);
      chk("l3_m3_d_rvalid", d_rvalid3, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
